// File: rtl/test_signal_scheduler.sv
// Round-robin arbiter for the shared test1 line: one requester at a time gets a
// pulse of its programmed length, then a guard gap precedes the next grant.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// DRIVE | grant held; test1 high while the latched length counts down
// GUARD | done issued; counting guard cycles before returning to IDLE
module test_signal_scheduler #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int GAP   = 2
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    test1
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    cnt, cnt_nxt;
    logic [PTR_W-1:0]    ptr, ptr_nxt;
    logic [NREQ-1:0]     gnt_nxt, done_nxt;
    logic                test1_nxt;

    logic [PTR_W-1:0]    sel;
    logic [PTR_W-1:0]    idx;
    logic                sel_vld;
    logic [LEN_W-1:0]    sel_len;
    logic [NREQ-1:0]     sel_oh;

    // Search starts just above the last winner so every requester gets a turn.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!sel_vld && req[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
        sel_len = len[int'(sel)*LEN_W +: LEN_W];
        sel_oh  = {{(NREQ-1){1'b0}}, 1'b1} << sel;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        test1_nxt = test1;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = sel_len;
                    ptr_nxt   = sel;
                    gnt_nxt   = sel_oh;
                    test1_nxt = (sel_len != '0);
                end
            end
            DRIVE: begin
                // A zero length also ends here, after a single granted cycle.
                if (cnt <= LEN_W'(1)) begin
                    state_nxt = GUARD;
                    cnt_nxt   = LEN_W'(GAP - 1);
                    gnt_nxt   = '0;
                    done_nxt  = gnt;
                    test1_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                test1_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= PTR_W'(NREQ - 1);
            gnt   <= '0;
            done  <= '0;
            test1 <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            test1 <= test1_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_test_signal_scheduler.sv
// Bench for test_signal_scheduler: directed and random requests checked each cycle
// against a timeline model (grant edge, pulse length, guard gap) of the scheduler.
module tb_test_signal_scheduler;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;
    localparam int GAP   = 2;

    logic                  clock = 1'b0;
    logic                  resetb;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  test1;

    test_signal_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP(GAP)) dut (
        .clock  (clock),
        .resetb (resetb),
        .req    (req),
        .len    (len),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .test1  (test1)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: one pulse described by its grant edge, length and owner.
    bit m_has;
    int m_g, m_len, m_dur, m_owner, m_ptr;
    int grant_log[$];
    bit auto_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lenf(input int i);
        return int'(len[i*LEN_W +: LEN_W]);
    endfunction

    function automatic int log_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_has = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic model_edge();
        int  n;
        bit  idle;
        bit  found;
        int  w;
        n = cyc;
        if (!resetb) return;
        idle = !m_has || (n - 1 >= m_g + m_dur + GAP);
        if (idle && req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                w = (m_ptr + k) % NREQ;
                if (!found && req[w]) begin
                    found   = 1'b1;
                    m_owner = w;
                end
            end
            m_has = 1'b1;
            m_g   = n;
            m_len = lenf(m_owner);
            m_dur = (m_len == 0) ? 1 : m_len;
            m_ptr = m_owner;
            grant_log.push_back(m_owner);
        end
    endtask

    task automatic expect_outputs();
        int              n;
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] oh, eg, ed;
        logic            et, eb;
        n   = cyc;
        one = 1;
        oh  = '0;
        eg  = '0;
        ed  = '0;
        et  = 1'b0;
        eb  = 1'b0;
        if (resetb && m_has) begin
            oh = one << m_owner;
            if (n >= m_g && n < m_g + m_dur)        eg = oh;
            if (n == m_g + m_dur)                   ed = oh;
            et = (n >= m_g && n < m_g + m_len);
            eb = (n >= m_g && n < m_g + m_dur + GAP);
        end
        check("gnt",   32'(gnt),   32'(eg));
        check("done",  32'(done),  32'(ed));
        check("test1", 32'(test1), 32'(et));
        check("busy",  32'(busy),  32'(eb));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        expect_outputs();
        if (auto_drop) req = req & ~done;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_len(input int i, input int v);
        len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    initial begin
        resetb    = 1'b0;
        req       = '0;
        len       = '0;
        auto_drop = 1'b0;
        model_reset();
        #12;
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_test1", 32'(test1), 32'd0);
        resetb = 1'b1;

        // All requesting, held: strict rotation starting at requester 0.
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        grant_log.delete();
        run(21);
        req = '0;
        run(10);
        check("rr_count", 32'(grant_log.size()), 32'd5);
        check("rr_0", 32'(log_at(0)), 32'd0);
        check("rr_1", 32'(log_at(1)), 32'd1);
        check("rr_2", 32'(log_at(2)), 32'd2);
        check("rr_3", 32'(log_at(3)), 32'd3);
        check("rr_4", 32'(log_at(4)), 32'd0);

        // Single request, length 3.
        auto_drop = 1'b1;
        set_len(0, 3);
        req = 4'b0001;
        run(10);

        // Move the pointer to 2, then check ordering across the wrap.
        set_len(2, 1);
        req = 4'b0100;
        run(8);
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        grant_log.delete();
        req = 4'b1011;
        run(20);
        check("wrap_count", 32'(grant_log.size()), 32'd3);
        check("wrap_0", 32'(log_at(0)), 32'd3);
        check("wrap_1", 32'(log_at(1)), 32'd0);
        check("wrap_2", 32'(log_at(2)), 32'd1);

        // Zero length on requester 1.
        set_len(1, 0);
        req = 4'b0010;
        run(8);

        // Request dropped during the second pulse cycle.
        set_len(0, 5);
        req = 4'b0001;
        run(2);
        req = 4'b0000;
        run(10);

        // Maximum length pulse.
        set_len(2, (1 << LEN_W) - 1);
        req = 4'b0100;
        run((1 << LEN_W) + 8);

        // Asynchronous reset during the second cycle of a 6-cycle pulse.
        set_len(0, 6);
        req = 4'b0001;
        run(2);
        resetb = 1'b0;
        model_reset();
        #1;
        check("arst_gnt",   32'(gnt),   32'd0);
        check("arst_done",  32'(done),  32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_test1", 32'(test1), 32'd0);
        set_len(0, 2);
        set_len(3, 2);
        req = 4'b1001;
        run(2);
        #3;
        resetb = 1'b1;
        grant_log.delete();
        run(15);
        check("arst_first",  32'(log_at(0)), 32'd0);
        check("arst_second", 32'(log_at(1)), 32'd3);

        // Random traffic: lengths change every cycle, requests hold until done.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_len(i, $urandom_range(0, 6));
                if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
            end
            step();
        end
        req = '0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
